// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;
    localparam int RD_LAT_DEF = 2;

    // Read-latency counter width; covers RD_LAT up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one history flop, rise = level high now, low last edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic hist_q;

    // History flop tracks the strobe every cycle, busy or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= 1'b0;
        else     hist_q <= sig_i;
    end

    assign rise_o = sig_i & ~hist_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: turns rd_mem/wr_mem strobe rises into accesses on an
// internal word array, returning rdata and a one-cycle done pulse.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN (out-of-range checks + err port).
//
// Handshake: an access starts on a strobe rise sampled while IDLE; busy is high
// while the access is in flight; done pulses for exactly one cycle when it
// completes, and busy is already low in that cycle. Rises seen while busy are
// dropped, never queued.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_mem,
    input  logic              wr_mem,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    logic rd_rise;
    logic wr_rise;

    rise_detect u_rd_rise (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (rd_mem),
        .rise_o (rd_rise)
    );

    rise_detect u_wr_rise (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (wr_mem),
        .rise_o (wr_rise)
    );

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                done_q;
    logic [DATA_W-1:0]   mem_q [0:(1<<ADDR_W)-1];

    // FSM-decoded controls
    logic load_rd;
    logic load_wr;
    logic rd_commit;
    logic wr_commit;
    logic wr_ok;
    logic [DATA_W-1:0] rd_word;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: a write rise wins over a simultaneous read rise.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_rise)      state_d = WRITE;
                else if (rd_rise) state_d = READ;
            end
            READ:    if (cnt_q == '0) state_d = IDLE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy and the datapath strobes.
    always_comb begin
        busy      = (state_q != IDLE);
        load_wr   = (state_q == IDLE) && wr_rise;
        load_rd   = (state_q == IDLE) && rd_rise && !wr_rise;
        rd_commit = (state_q == READ) && (cnt_q == '0);
        wr_commit = (state_q == WRITE);
    end

    // Latency counter next value: load on read start, count down in READ.
    always_comb begin
        cnt_d = cnt_q;
        if (load_rd)                                cnt_d = CNT_LOAD;
        else if ((state_q == READ) && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    logic oor_q;
    logic conflict_q;
    logic err_q;

    // Range/conflict flags captured at access start, reported with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oor_q      <= 1'b0;
            conflict_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (load_rd || load_wr) begin
                oor_q      <= (addr[31:ADDR_W] != '0);
                conflict_q <= load_wr && rd_rise;
            end
            err_q <= (rd_commit || wr_commit) && (oor_q || conflict_q);
        end
    end

    assign wr_ok   = !oor_q;
    assign rd_word = oor_q ? '0 : mem_q[addr_q];
    assign err     = err_q;
`else
    // Upper address bits alias away in this build.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W];

    assign wr_ok   = 1'b1;
    assign rd_word = mem_q[addr_q];
`endif

    // Datapath registers: latched request, counter, read data and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= rd_commit || wr_commit;
            if (load_rd || load_wr) addr_q <= addr[ADDR_W-1:0];
            if (load_wr)            wdata_q <= wdata;
            if (rd_commit)          rdata_q <= rd_word;
        end
    end

    // Word array, not reset; a write only commits from the WRITE state, which
    // reset leaves asynchronously, so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (wr_commit && wr_ok) mem_q[addr_q] <= wdata_q;
    end

    assign rdata = rdata_q;
    assign done  = done_q;

endmodule
